// File: rtl/div_pkg.sv
// Shared constants and types for the radix-4 restoring divider.
package div_pkg;

    // Default operand width; the dividend is twice this wide.
    localparam int unsigned DEF_W = 30;

    // Radix-4 iterations per operation (two radix-2 steps each).
    localparam int unsigned ITERS = 15;

    // Width of the iteration counter.
    localparam int unsigned CNT_W = $clog2(ITERS);

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int unsigned W = 30
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] quo_i,
    input  logic [W-1:0] den_i,
    output logic [W-1:0] rem_o,
    output logic [W-1:0] quo_o
);

    logic [W:0] trial;
    logic [W:0] diff;
    logic       ge;

    // Trial subtraction at W+1 bits so the shifted-out remainder bit is never lost.
    always_comb begin
        trial = {rem_i, quo_i[W-1]};
        diff  = trial - {1'b0, den_i};
        // rem_i < den_i keeps a non-negative diff below 2^W, so bit W is a pure borrow.
        ge    = ~diff[W];
        rem_o = ge ? diff[W-1:0] : trial[W-1:0];
        quo_o = {quo_i[W-2:0], ge};
    end

endmodule

// File: rtl/div.sv
// Unsigned 2W/W divider, radix-4 restoring, fixed 15-cycle latency.
module div
    import div_pkg::*;
#(
    parameter int unsigned W = DEF_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [2*W-1:0] c,
    input  logic [W-1:0]   a,
    output logic [W-1:0]   b,
    output logic [W-1:0]   r,
    output logic           busy,
    output logic           done,
    output logic           ovf
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     rem_q, rem_d;
    logic [W-1:0]     quo_q, quo_d;
    logic [W-1:0]     den_q, den_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     r_q, r_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;

    logic [W-1:0]     rem_mid, quo_mid;
    logic [W-1:0]     rem_nxt, quo_nxt;
    logic [W-1:0]     c_hi;

    assign c_hi = c[2*W-1:W];

    div_step #(
        .W(W)
    ) u_step0 (
        .rem_i(rem_q),
        .quo_i(quo_q),
        .den_i(den_q),
        .rem_o(rem_mid),
        .quo_o(quo_mid)
    );

    div_step #(
        .W(W)
    ) u_step1 (
        .rem_i(rem_mid),
        .quo_i(quo_mid),
        .den_i(den_q),
        .rem_o(rem_nxt),
        .quo_o(quo_nxt)
    );

    // Next-state: accept/overflow detection in idle, two radix-2 steps per cycle in run.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        den_d   = den_q;
        b_d     = b_q;
        r_d     = r_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    // Quotient would not fit in W bits (covers a == 0 as well).
                    if (a == '0 || c_hi >= a) begin
                        ovf_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        ovf_d   = 1'b0;
                        den_d   = a;
                        rem_d   = c_hi;
                        quo_d   = c[W-1:0];
                        cnt_d   = '0;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                rem_d = rem_nxt;
                quo_d = quo_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITERS - 1)) begin
                    b_d     = quo_nxt;
                    r_d     = rem_nxt;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous reset; reset aborts any operation without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            den_q   <= '0;
            b_q     <= '0;
            r_q     <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            den_q   <= den_d;
            b_q     <= b_d;
            r_q     <= r_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign b    = b_q;
    assign r    = r_q;
    assign busy = (state_q == StRun);
    assign done = done_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for the divider.
module tb_div;

    localparam int unsigned W = 30;

    logic           clk;
    logic           reset;
    logic           start;
    logic [2*W-1:0] c;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   r;
    logic           busy;
    logic           done;
    logic           ovf;

    int checks = 0;
    int errors = 0;

    div #(
        .W(W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .c    (c),
        .a    (a),
        .b    (b),
        .r    (r),
        .busy (busy),
        .done (done),
        .ovf  (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Start an operation, hold start for 'hold' cycles, scramble inputs, wait for done.
    // lat counts edges after the accept edge until done is seen.
    task automatic op(input logic [2*W-1:0] cc, input logic [W-1:0] aa, input int hold,
                      output int lat, output logic busy_t);
        c     = cc;
        a     = aa;
        start = 1'b1;
        tick();
        busy_t = busy;
        lat    = 0;
        for (int i = 1; i < hold; i++) begin
            tick();
            lat++;
        end
        start = 1'b0;
        c     = {$urandom(), $urandom()};
        a     = W'($urandom());
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    int          lat;
    logic        bt;
    int          pulses;
    logic [W-1:0] m;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        c     = '0;
        a     = '0;
        m     = '1;
        tick();
        tick();
        chk("rst_b", 64'(b), 64'd0);
        chk("rst_r", 64'(r), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        reset = 1'b0;
        tick();

        // Nominal, start held for 3 cycles.
        op(60'd2098570923875, 30'd837504, 3, lat, bt);
        chk("nom_busy", 64'(bt), 64'd1);
        chk("nom_lat", 64'(lat), 64'd15);
        chk("nom_b", 64'(b), 64'd2505744);
        chk("nom_r", 64'(r), 64'd300899);
        chk("nom_ovf", 64'(ovf), 64'd0);
        tick();
        chk("nom_done_once", 64'(done), 64'd0);
        chk("nom_idle", 64'(busy), 64'd0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) pulses++;
        end
        chk("nom_no_extra", 64'(pulses), 64'd0);

        // Overflow: high half equals divisor.
        op({30'd837504, 30'd0}, 30'd837504, 1, lat, bt);
        chk("ovf_busy", 64'(bt), 64'd0);
        chk("ovf_lat", 64'(lat), 64'd0);
        chk("ovf_flag", 64'(ovf), 64'd1);
        chk("ovf_b", 64'(b), 64'd2505744);
        chk("ovf_r", 64'(r), 64'd300899);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busy || done) pulses++;
        end
        chk("ovf_quiet", 64'(pulses), 64'd0);
        chk("ovf_hold", 64'(ovf), 64'd1);

        // Max quotient.
        op(60'd1073741823, 30'd1, 1, lat, bt);
        chk("maxq_lat", 64'(lat), 64'd15);
        chk("maxq_b", 64'(b), 64'd1073741823);
        chk("maxq_r", 64'(r), 64'd0);
        chk("maxq_ovf", 64'(ovf), 64'd0);

        // Back-to-back: start on the done cycle.
        op(60'd10, 30'd3, 1, lat, bt);
        chk("b2b_busy", 64'(bt), 64'd1);
        chk("b2b_lat", 64'(lat), 64'd15);
        chk("b2b_b", 64'(b), 64'd3);
        chk("b2b_r", 64'(r), 64'd1);
        tick();

        // Divide by zero.
        op(60'd123456, 30'd0, 1, lat, bt);
        chk("dz_busy", 64'(bt), 64'd0);
        chk("dz_lat", 64'(lat), 64'd0);
        chk("dz_ovf", 64'(ovf), 64'd1);
        chk("dz_b", 64'(b), 64'd3);
        chk("dz_r", 64'(r), 64'd1);
        tick();
        chk("dz_done_once", 64'(done), 64'd0);

        // Divisor near 2^W-1: c = m*m + (m-1).
        op({m - 30'd1, m}, m, 1, lat, bt);
        chk("wide_lat", 64'(lat), 64'd15);
        chk("wide_b", 64'(b), 64'(m));
        chk("wide_r", 64'(r), 64'(m - 30'd1));
        chk("wide_ovf", 64'(ovf), 64'd0);
        tick();

        // Reset at T+7 aborts the operation.
        c     = 60'd5000;
        a     = 30'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_b", 64'(b), 64'd0);
        chk("mid_r", 64'(r), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_done", 64'(done), 64'd0);
        chk("mid_ovf", 64'(ovf), 64'd0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done || busy) pulses++;
        end
        chk("mid_no_done", 64'(pulses), 64'd0);

        op(60'd100, 30'd7, 1, lat, bt);
        chk("post_lat", 64'(lat), 64'd15);
        chk("post_b", 64'(b), 64'd14);
        chk("post_r", 64'(r), 64'd2);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
